// File: rtl/de_selector_counter.sv
// de_selector_counter: synchronised per-channel edge counters for an active-low 1-of-4 de-selector,
// with a clear-on-read port and a sticky illegal-multi-select flag.
module de_selector_counter #(
   parameter int CNT_W       = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic             iClk,
   input  logic             iRst_n,
   input  logic             iZ0,
   input  logic             iZ1,
   input  logic             iZ2,
   input  logic             iZ3,
   input  logic             iRd,
   input  logic [1:0]       iRdSel,
   input  logic             iClr,
   output logic [CNT_W-1:0] oData,
   output logic             oValid,
   output logic [1:0]       oActive,
   output logic             oAny,
   output logic             oErr
);
   logic [SYNC_STAGES-1:0][3:0]  sync_q, sync_d;
   logic [SYNC_STAGES-1:0]       rdy_q, rdy_d;
   logic [3:0]                   p_q, p_d, s, hit;
   logic [3:0][CNT_W-1:0]        cnt_q, cnt_d;
   logic [CNT_W-1:0]             data_q, data_d;
   logic [1:0]                   act_q, act_d;
   logic                         valid_q, valid_d, any_q, any_d, err_q, err_d, multi;
   always_comb begin
      sync_d  = {sync_q[SYNC_STAGES-2:0], {iZ3, iZ2, iZ1, iZ0}};
      rdy_d   = {rdy_q[SYNC_STAGES-2:0], 1'b1};
      s       = sync_q[SYNC_STAGES-1];
      // history stays low until the synchroniser holds real samples, so a line low at release is not an edge
      p_d     = rdy_q[SYNC_STAGES-1] ? s : 4'h0;
      multi   = $countones(~s) > 1;
      hit     = multi ? 4'h0 : (p_q & ~s);
      any_d   = s != 4'hF;
      err_d   = !iClr && (err_q || multi);
      act_d   = hit[0] ? 2'd0 : hit[1] ? 2'd1 : hit[2] ? 2'd2 : hit[3] ? 2'd3 : act_q;
      valid_d = iRd;
      data_d  = iRd ? cnt_q[iRdSel] : data_q;
      for (int n = 0; n < 4; n++) begin
         cnt_d[n] = (iRd && iRdSel == 2'(n)) ? '0 : cnt_q[n];
         if (hit[n] && cnt_d[n] != '1) cnt_d[n] = cnt_d[n] + CNT_W'(1);
         if (iClr) cnt_d[n] = '0;
      end
   end
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         sync_q  <= '1;
         rdy_q   <= '0;
         p_q     <= '1;
         cnt_q   <= '0;
         data_q  <= '0;
         act_q   <= '0;
         valid_q <= 1'b0;
         any_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         rdy_q   <= rdy_d;
         p_q     <= p_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         act_q   <= act_d;
         valid_q <= valid_d;
         any_q   <= any_d;
         err_q   <= err_d;
      end
   end
   assign oData   = data_q;
   assign oValid  = valid_q;
   assign oActive = act_q;
   assign oAny    = any_q;
   assign oErr    = err_q;
endmodule

// File: doc/de_selector_counter.md
# de_selector_counter

- Per-channel event counter downstream of the 1-to-4 active-low de-selector.
- Samples the four active-low select lines, synchronises them into the iClk domain, detects each assertion (high-to-low edge) and keeps a saturating count per channel.
- Flags illegal multi-line assertion, which the de-selector can never legally produce.
- Counters are read one at a time through a clear-on-read port.

## Interface
Parameters:
- CNT_W, 8, width of each channel counter and of oData (legal range 2..16).
- SYNC_STAGES, 2, flip-flop depth of the input synchroniser (legal range 2..4).

Ports:
- iClk  in  1  system clock; all state updates on its rising edge.
- iRst_n  in  1  reset, asynchronous assert, active-low.
- iZ0..iZ3  in  1 each  active-low channel lines from the de-selector; asynchronous to iClk.
- iRd  in  1  read strobe, one cycle, sampled on rising edge.
- iRdSel  in  2  channel index to read (0..3), sampled with iRd.
- iClr  in  1  synchronous clear of all counters and the error flag.
- oData  out  CNT_W  count returned by the last read.
- oValid  out  1  one-cycle pulse; oData valid.
- oActive  out  2  index of the most recently counted channel.
- oAny  out  1  high while any synchronised line is low.
- oErr  out  1  sticky flag; more than one line low in the same cycle.

## Operation
- Reset (iRst_n=0):
  - All synchroniser flops and edge-history flops set to 1 (deasserted), so release from reset never produces a false edge.
  - All counters, oData, oValid, oActive, oAny and oErr go to 0.
- Synchroniser: each iZn passes through SYNC_STAGES flops; the last stage is the synchronised line sZn.
- Edge detect: one history flop pZn per channel. An edge on channel n is pZn=1 and sZn=0 in the same cycle.
- Low count L = number of sZn equal to 0 in the current cycle.
- Case L>=2:
  - oErr is set and held until iClr or reset.
  - All edges in that cycle are discarded; no counter changes.
  - oActive holds its value.
- Case L<=1:
  - An edge on channel n increments counter n by 1.
  - Counter n saturates at 2^CNT_W-1 and does not wrap.
  - oActive is set to n.
- oAny is registered: it shows, one cycle late, whether L>=1.
- Read (iRd=1):
  - oData is loaded with counter[iRdSel] as it was before that cycle's update.
  - oValid pulses on the next cycle.
  - counter[iRdSel] is cleared on the same edge.
- Read and edge on the same channel in the same cycle: oData returns the pre-increment value and the counter becomes 1. The event is not lost.
- iClr=1:
  - All counters and oErr are cleared.
  - iClr takes priority over increments and over the read-clear.
- Read and iClr in the same cycle: the read still returns the pre-clear value.
- oData holds its last value until the next read.

## Timing
- Counting latency: assume iZn is first sampled low at rising edge E0.
  - sZn goes low after edge E0+(SYNC_STAGES-1).
  - The counter, oActive and oAny update at edge E0+SYNC_STAGES.
  - With SYNC_STAGES=2, the count is visible 2 edges after first sampling.
- Read latency: iRd is sampled at edge R; oData and oValid are valid after R+1 for exactly one cycle.
- Read throughput: back-to-back reads on consecutive cycles are legal, one result per cycle.
- Pulse width:
  - Each low pulse on iZn counts once, however long it lasts.
  - A pulse must be low for at least 2 iClk cycles and high for at least 2 iClk cycles between pulses to be counted reliably.
  - Shorter glitches may be missed; they must never be double-counted.
- Reset mid-operation: when iRst_n asserts, state clears immediately, whatever the synchroniser contents.
- Reset with a line held low: a line held low through reset release is not counted until it goes high and then low again.

## Test plan
- Reset release with iZ0..iZ3=1 -> all outputs 0 and no counts. Hold iZ2=0 across release -> counter2 stays 0 until iZ2 goes high then low; then reading 2 returns 1.
- Three 4-cycle low pulses on iZ1, then iRd with iRdSel=1 -> oData=3 with oValid high for one cycle, oActive=1. An immediate second read of 1 -> oData=0.
- CNT_W=2, six pulses on iZ3, then read 3 -> oData=3 (saturated, no wrap).
- iZ0 and iZ3 low in the same cycle -> oErr=1 and neither counter increments. Then iClr pulse -> oErr=0 and all counters 0.
- Read of channel 0 issued on the same cycle an edge on channel 0 reaches the edge detector -> oData is the old count N, and the following read of 0 returns 1.
- iRst_n pulsed low for 1 cycle in the middle of a read and pulse sequence -> oValid, oData and all counters read 0 afterwards, and counting resumes normally.
